bias_add_sequencer: RTL and testbench

- Sequences the per-layer bias constants into the adder-tree output stream.
- Accepts N_adder_tree-lane partial-sum beats from the adder tree and walks output-channel groups.
- For each group, selects that group's 16-lane bias vector from a flat bias bus fed by the BIAS_layerX_* constant banks, saturating-adds it, and emits the result over a valid/ready handshake.
- Sits between the adder tree and the activation/requantise stage. Signals layer completion to the layer controller.

---
 rtl/bias_add_sequencer_pkg.sv | 41 ++++
 rtl/bias_add_sequencer_lane.sv | 33 +++
 rtl/bias_add_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_bias_add_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bias_add_sequencer_pkg
// Shared definitions for the bias-add sequencer: lane data width, saturation
// limits, FSM state encoding and small constant-evaluation helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package bias_add_sequencer_pkg;

    // Lane data width (two's complement)
    localparam int DW = 18;

    // Largest positive and most negative DW-bit two's complement values
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Bit offset of the low bit of a lane inside a packed lane vector
    function automatic int lane_lo(input int lane);
        return lane * DW;
    endfunction

endpackage

// File: rtl/bias_add_sequencer_lane.sv
// -----------------------------------------------------------------------------
// bias_sat_add_lane
// Combinational saturating add of one data lane and one bias lane.
// Both operands are sign-extended by one bit so the sum cannot wrap; the two
// top bits of the wide sum then tell whether the true result fits in DW bits.
// Ports:
//   in_lane   in  DW  partial sum from the adder tree
//   bias_lane in  DW  bias constant for this lane
//   out_lane  out DW  saturated sum
// -----------------------------------------------------------------------------
module bias_sat_add_lane
    import bias_add_sequencer_pkg::*;
(
    input  logic [DW-1:0] in_lane,
    input  logic [DW-1:0] bias_lane,
    output logic [DW-1:0] out_lane
);

    logic [DW:0] sum_s;

    // Wide add followed by clamp to the DW-bit signed range
    always_comb begin
        sum_s = {in_lane[DW-1], in_lane} + {bias_lane[DW-1], bias_lane};
        if (sum_s[DW] == sum_s[DW-1]) begin
            out_lane = sum_s[DW-1:0];
        end else if (sum_s[DW]) begin
            out_lane = SAT_MIN;
        end else begin
            out_lane = SAT_MAX;
        end
    end

endmodule

// File: rtl/bias_add_sequencer.sv
// -----------------------------------------------------------------------------
// bias_add_sequencer
// Adds the current output-channel group's bias vector to each adder-tree beat,
// saturates per lane and forwards the result over a valid/ready handshake.
// Walks N_GROUPS groups of PIX_PER_GROUP beats per layer, then pulses done.
// Ports:
//   clk        in   1                     system clock, rising edge
//   rst_n      in   1                     asynchronous active-low reset
//   start      in   1                     begins a layer pass (IDLE only)
//   bias_bus   in   N_GROUPS*N*DW         bias constants, group g in slice g
//   in_data    in   N*DW                  adder-tree sums, lane i in slice i
//   in_valid   in   1                     in_data valid
//   in_ready   out  1                     block accepts in_data this cycle
//   out_data   out  N*DW                  biased, saturated sums
//   out_valid  out  1                     out_data valid
//   out_ready  in   1                     downstream accepts
//   out_last   out  1                     final beat of the layer
//   grp_idx    out  clog2(N_GROUPS)       current group counter
//   busy       out  1                     high in RUN or DRAIN
//   done       out  1                     one-cycle layer-complete pulse
// -----------------------------------------------------------------------------
module bias_add_sequencer
    import bias_add_sequencer_pkg::*;
#(
    parameter  int N_adder_tree  = 16,
    parameter  int N_GROUPS      = 4,
    parameter  int PIX_PER_GROUP = 64,
    localparam int GW = (clog2(N_GROUPS) > 0) ? clog2(N_GROUPS) : 1,
    localparam int LW = N_adder_tree * DW
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_GROUPS*LW-1:0] bias_bus,
    input  logic [LW-1:0]          in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [GW-1:0]          grp_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int BUS_W = N_GROUPS * LW;
    localparam int OW    = clog2(BUS_W);
    localparam int PW    = (clog2(PIX_PER_GROUP) > 0) ? clog2(PIX_PER_GROUP) : 1;

    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_GROUP - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUPS - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [LW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic            in_ready_s;
    logic            accept_s;
    logic            final_s;
    logic [OW-1:0]   grp_base_s;
    logic [LW-1:0]   sum_s;

    // Handshake and end-of-layer decode; a held output blocks new input
    always_comb begin
        in_ready_s = (state_q == RUN) && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready_s;
        final_s    = (pix_q == PIX_LAST) && (grp_q == GRP_LAST);
        grp_base_s = OW'(grp_q) * OW'(LW);
    end

    // Per-lane bias select and saturating add
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic [OW-1:0] lane_off_s;
        logic [DW-1:0] bias_lane_s;

        assign lane_off_s  = grp_base_s + OW'(lane_lo(i));
        assign bias_lane_s = bias_bus[lane_off_s +: DW];

        bias_sat_add_lane u_lane (
            .in_lane   (in_data[lane_lo(i) +: DW]),
            .bias_lane (bias_lane_s),
            .out_lane  (sum_s[lane_lo(i) +: DW])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s && final_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy     = (state_q == RUN) || (state_q == DRAIN);
        done     = (state_q == DONE);
        in_ready = in_ready_s;
    end

    // Pixel/group counters: cleared on layer start, advanced on accept
    always_comb begin
        pix_d = pix_q;
        grp_d = grp_q;
        if ((state_q == IDLE) && start) begin
            pix_d = '0;
            grp_d = '0;
        end else if (accept_s) begin
            if (pix_q == PIX_LAST) begin
                pix_d = '0;
                if (grp_q == GRP_LAST) begin
                    grp_d = '0;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end else begin
                pix_d = pix_q + PW'(1);
            end
        end else begin
            pix_d = pix_q;
            grp_d = grp_q;
        end
    end

    // Output stage: load on accept, clear once consumed, hold while stalled
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (accept_s) begin
            out_data_d  = sum_s;
            out_valid_d = 1'b1;
            out_last_d  = final_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q       <= '0;
            grp_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            grp_q       <= grp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign grp_idx   = grp_q;

endmodule

// File: tb/tb_bias_add_sequencer.sv
module tb_bias_add_sequencer;

    localparam int N     = 16;
    localparam int G     = 4;
    localparam int PIX   = 4;
    localparam int DW    = 18;
    localparam int W     = N * DW;
    localparam int CW    = W + 8;
    localparam int BEATS = G * PIX;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [G*W-1:0] bias_bus = '0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_last;
    logic [1:0]     grp_idx;
    logic           busy;
    logic           done;

    bias_add_sequencer #(
        .N_adder_tree  (N),
        .N_GROUPS      (G),
        .PIX_PER_GROUP (PIX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias_bus  (bias_bus),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .grp_idx   (grp_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } exp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] y;
    } sat_vec_t;

    exp_t          exp_q[$];
    sat_vec_t      tbl[BEATS];
    logic [DW-1:0] bias_v[G][N];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_hs_cyc = 0;
    int            beats_out = 0;
    bit            bp_mode = 1'b0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int to_int(input logic [DW-1:0] v);
        return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
    endfunction

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        int hi;
        int lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        s  = to_int(a) + to_int(b);
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        return DW'(s);
    endfunction

    function automatic logic [W-1:0] model_beat(input logic [W-1:0] d, input int g);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = sat_add(d[i*DW +: DW], bias_v[g][i]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_lane();
        logic [DW-1:0] r;
        r = DW'($urandom);
        case ($urandom_range(0, 3))
            0: return 18'h1FFFF - (r & 18'h000FF);
            1: return 18'h20000 + (r & 18'h000FF);
            default: return r;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = rnd_lane();
        return d;
    endfunction

    task automatic set_bias();
        for (int g = 0; g < G; g++)
            for (int i = 0; i < N; i++)
                bias_bus[(g*N + i)*DW +: DW] = bias_v[g][i];
    endtask

    // ---------------- clock-side processes ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor / scoreboard
    initial begin : monitor
        exp_t         e;
        logic         stall_prev;
        logic [W:0]   held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("stall_hold", CW'({out_valid, out_last, out_data}), CW'({1'b1, held}));
                if (out_valid && out_ready) begin
                    chk("beat_pending", CW'(exp_q.size() > 0), CW'(1'b1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat_data", CW'(out_data), CW'(e.data));
                        chk("beat_last", CW'(out_last), CW'(e.last));
                        if (e.last) last_hs_cyc = cyc;
                    end
                    beats_out++;
                end
                if (out_valid && !out_ready) begin
                    chk("in_ready_stall", CW'(in_ready), CW'(1'b0));
                    stall_prev = 1'b1;
                    held       = {out_last, out_data};
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic start_layer();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats_out = 0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [W-1:0] exp_d,
                             input logic exp_last, input int exp_grp);
        exp_t e;
        logic got;
        got      = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("grp_idx_at_accept", CW'(grp_idx), CW'(exp_grp));
                e.last = exp_last;
                e.data = exp_d;
                exp_q.push_back(e);
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", CW'(got), CW'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", CW'(seen), CW'(1'b1));
        chk("done_latency", CW'(cyc - last_hs_cyc), CW'(1));
        chk("busy_at_done", CW'(busy), CW'(1'b0));
        chk("beat_count", CW'(beats_out), CW'(BEATS));
        chk("queue_empty", CW'(exp_q.size()), CW'(0));
        @(negedge clk);
        chk("post_done", CW'({busy, done, in_ready}), CW'(3'b000));
    endtask

    // mode 0: group walk, 1: random, 2: random with bubbles, 3: saturation table
    task automatic run_layer(input int mode);
        logic [W-1:0] d;
        logic [W-1:0] e;
        int g;
        for (int gg = 0; gg < G; gg++)
            for (int i = 0; i < N; i++)
                bias_v[gg][i] = (mode == 0) ? DW'(gg*N + i) : rnd_lane();
        set_bias();
        start_layer();
        chk("busy_run", CW'(busy), CW'(1'b1));
        for (int k = 0; k < BEATS; k++) begin
            g = k / PIX;
            if (mode == 0) begin
                d = '0;
                for (int i = 0; i < N; i++) e[i*DW +: DW] = DW'(g*N + i);
            end else if (mode == 3) begin
                for (int gg = 0; gg < G; gg++)
                    for (int i = 0; i < N; i++) bias_v[gg][i] = tbl[k].b;
                set_bias();
                d = {N{tbl[k].a}};
                e = {N{tbl[k].y}};
            end else begin
                d = rnd_beat();
                e = model_beat(d, g);
            end
            send_beat(d, e, k == BEATS-1, g);
            if (mode == 2 && k < BEATS-1) begin
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bubble_grp", CW'(grp_idx), CW'(((k+1)/PIX) % G));
                    if (j == 2) chk("bubble_drain", CW'(out_valid), CW'(1'b0));
                end
                @(posedge clk); #1;
            end
        end
        wait_done();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] d;
        tbl[0]  = '{18'h1FFF0, 18'h00100, 18'h1FFFF};
        tbl[1]  = '{18'h20010, 18'h3FF00, 18'h20000};
        tbl[2]  = '{18'h00005, 18'h3FFFD, 18'h00002};
        tbl[3]  = '{18'h00000, 18'h00000, 18'h00000};
        tbl[4]  = '{18'h1FFFF, 18'h00001, 18'h1FFFF};
        tbl[5]  = '{18'h20000, 18'h3FFFF, 18'h20000};
        tbl[6]  = '{18'h1FFFF, 18'h20000, 18'h3FFFF};
        tbl[7]  = '{18'h12345, 18'h00001, 18'h12346};
        tbl[8]  = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFE};
        tbl[9]  = '{18'h0FFFF, 18'h10000, 18'h1FFFF};
        tbl[10] = '{18'h10000, 18'h10000, 18'h1FFFF};
        tbl[11] = '{18'h30000, 18'h30000, 18'h20000};
        tbl[12] = '{18'h2FFFF, 18'h30000, 18'h20000};
        tbl[13] = '{18'h00010, 18'h3FFF0, 18'h00000};
        tbl[14] = '{18'h1FFFE, 18'h00001, 18'h1FFFF};
        tbl[15] = '{18'h20001, 18'h3FFFF, 18'h20000};

        // Reset values and idle behaviour with in_valid asserted
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #12;
        chk("reset_ctrl", CW'({in_ready, out_valid, out_last, done, busy, grp_idx}), CW'(7'd0));
        chk("reset_data", CW'(out_data), CW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_hold", CW'({in_ready, out_valid, busy}), CW'(3'b000));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        bp_mode = 1'b0;
        run_layer(0);
        run_layer(3);
        bp_mode = 1'b1;
        run_layer(1);
        run_layer(1);
        bp_mode = 1'b0;
        run_layer(2);

        // Start ignored mid-layer, then abort with reset after beat 6
        for (int gg = 0; gg < G; gg++)
            for (int i = 0; i < N; i++) bias_v[gg][i] = rnd_lane();
        set_bias();
        start_layer();
        for (int k = 0; k < 6; k++) begin
            d = rnd_beat();
            send_beat(d, model_beat(d, k / PIX), 1'b0, k / PIX);
            if (k == 2) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("start_ignored_busy", CW'(busy), CW'(1'b1));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", CW'({in_ready, out_valid, out_last, done, busy, grp_idx}), CW'(7'd0));
        chk("abort_data", CW'(out_data), CW'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("no_done_after_abort", CW'({done, busy, out_valid}), CW'(3'b000));
        end
        run_layer(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
